ceespu_video_timing: RTL and testbench

Pixel-clock raster generator for the ceespu video path: produces the 640x480@60 scan coordinates (x, y) that drive ceespu_gpu, plus hsync/vsync/data-enable for the HDMI controller. The control outputs are delayed to line up with the gpu's pixel output, which lags the coordinates by two RAM reads (text/colour RAM, then font RAM). The block also exports a frame-start pulse and a vblank level as CPU-visible status.

---
 rtl/ceespu_video_pkg.sv | 30 +++
 rtl/ceespu_delay_line.sv | 27 ++
 rtl/ceespu_video_timing.sv | 93 +++++++++
 tb/tb_ceespu_video_timing.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceespu_video_pkg.sv
// Shared 640x480@60 raster constants for the ceespu video path.
// Counter and coordinate widths live here so the top and the bench agree.
package ceespu_video_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic        SYNC_POL   = 1'b0;
  localparam int unsigned PIPE_DELAY = 2;

  // v_cnt reaches 524, so it needs one bit more than y
  localparam int unsigned CNT_W = 10;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

endpackage

// File: rtl/ceespu_delay_line.sv
// Fixed-depth register chain with a synchronous active-low clear to RST_VAL.
// Every stage is cleared together so nothing in flight survives a reset.
module ceespu_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/ceespu_video_timing.sv
// Pixel-clock raster generator: scan coordinates for the gpu plus sync/de
// delayed to match the gpu's two-RAM-read pixel latency, and CPU status bits.
module ceespu_video_timing
  import ceespu_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = ceespu_video_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = ceespu_video_pkg::H_FP,
  parameter int unsigned H_SYNC     = ceespu_video_pkg::H_SYNC,
  parameter int unsigned H_BP       = ceespu_video_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = ceespu_video_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = ceespu_video_pkg::V_FP,
  parameter int unsigned V_SYNC     = ceespu_video_pkg::V_SYNC,
  parameter int unsigned V_BP       = ceespu_video_pkg::V_BP,
  parameter logic        SYNC_POL   = ceespu_video_pkg::SYNC_POL,
  parameter int unsigned PIPE_DELAY = ceespu_video_pkg::PIPE_DELAY
) (
  input  logic           I_pix_clk,
  input  logic           I_rst_n,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           O_hsync,
  output logic           O_vsync,
  output logic           O_de,
  output logic           O_frame_start,
  output logic           O_vblank
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_FIN = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_FIN = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // chain order {vsync, hsync, de}; idle means syncs deasserted, de low
  localparam logic [2:0] PIPE_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_vis;
  logic             v_vis;
  logic             hs_raw;
  logic             vs_raw;
  logic             de_raw;
  logic [2:0]       pipe_d;
  logic [2:0]       pipe_q;

  // raster counters; v advances on the h wrap, both wrap together at the corner
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign h_vis  = (h_cnt < H_VIS);
  assign v_vis  = (v_cnt < V_VIS);
  assign de_raw = h_vis && v_vis;
  assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_FIN);
  assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_FIN);

  assign x = h_vis ? X_W'(h_cnt) : '0;
  assign y = v_vis ? v_cnt[Y_W-1:0] : '0;

  assign O_frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign O_vblank      = !v_vis;

  // polarity applied before the chain so cleared stages already read as idle
  assign pipe_d = {vs_raw ? SYNC_POL : ~SYNC_POL,
                   hs_raw ? SYNC_POL : ~SYNC_POL,
                   de_raw};

  ceespu_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (PIPE_IDLE)
  ) u_pipe (
    .clk   (I_pix_clk),
    .rst_n (I_rst_n),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  assign {O_vsync, O_hsync, O_de} = pipe_q;

endmodule

// File: tb/tb_ceespu_video_timing.sv
// Bench for ceespu_video_timing: a full-size raster and a shrunken raster
// with PIPE_DELAY=1, both checked every cycle against a position-based model.
module tb_ceespu_video_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
  } obs_t;

  logic clk = 1'b0;
  logic rst_m, rst_s;
  logic [9:0] x_m, x_s;
  logic [8:0] y_m, y_s;
  logic hs_m, vs_m, de_m, fs_m, vb_m;
  logic hs_s, vs_s, de_s, fs_s, vb_s;

  int checks = 0;
  int errors = 0;
  int shown  = 0;
  int pos_m  = 0;
  int pos_s  = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  ceespu_video_timing u_main (
    .I_pix_clk(clk), .I_rst_n(rst_m), .x(x_m), .y(y_m),
    .O_hsync(hs_m), .O_vsync(vs_m), .O_de(de_m),
    .O_frame_start(fs_m), .O_vblank(vb_m)
  );

  ceespu_video_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .PIPE_DELAY(1)
  ) u_small (
    .I_pix_clk(clk), .I_rst_n(rst_s), .x(x_s), .y(y_s),
    .O_hsync(hs_s), .O_vsync(vs_s), .O_de(de_s),
    .O_frame_start(fs_s), .O_vblank(vb_s)
  );

  // Outputs as a function of cycles since reset release p and pipe depth d.
  function automatic obs_t model(input int p, input int d,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp);
    obs_t e;
    int ht, vt, h, v, hp, vp;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.x  = (h < ha) ? 10'(h) : 10'd0;
    e.y  = (v < va) ? 9'(v) : 9'd0;
    e.fs = (h == 0) && (v == 0);
    e.vb = (v >= va);
    if (p < d) begin
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      hp = (p - d) % ht;
      vp = ((p - d) / ht) % vt;
      e.de = (hp < ha) && (vp < va);
      e.hs = !((hp >= ha + hfp) && (hp < ha + hfp + hsw));
      e.vs = !((vp >= va + vfp) && (vp < va + vfp + vsw));
    end
    return e;
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos_m(input int target);
    int n = 0;
    while (pos_m != target && n < 100000) begin step(); n++; end
    if (pos_m != target) chk("timeout_main", pos_m, target);
  endtask

  task automatic wait_pos_s(input int target);
    int n = 0;
    while (pos_s != target && n < 100000) begin step(); n++; end
    if (pos_s != target) chk("timeout_small", pos_s, target);
  endtask

  // position tracking: cycles since the last reset edge
  always @(posedge clk) begin
    if (!rst_m) pos_m = 0; else pos_m = pos_m + 1;
    if (!rst_s) pos_s = 0; else pos_s = pos_s + 1;
    if (!rst_m && !rst_s) armed = 1'b1;
  end

  obs_t got_m, exp_m, got_s, exp_s;

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (armed) begin
      got_m = {x_m, y_m, de_m, hs_m, vs_m, fs_m, vb_m};
      exp_m = model(pos_m, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      checks++;
      if (got_m !== exp_m) begin
        errors++;
        if (shown < 20) $display("FAIL raster_main pos=%0d got=%h expected=%h", pos_m, got_m, exp_m);
        shown++;
      end
      got_s = {x_s, y_s, de_s, hs_s, vs_s, fs_s, vb_s};
      exp_s = model(pos_s, 1, 16, 2, 4, 3, 6, 2, 2, 3);
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        if (shown < 20) $display("FAIL raster_small pos=%0d got=%h expected=%h", pos_s, got_s, exp_s);
        shown++;
      end
    end
  end

  // main-instance edge/run recorder
  int de_rise[$], de_len[$], hs_start[$], hs_len[$];
  int de_run = 0, hs_run = 0;
  logic de_mp = 1'b0, hs_mp = 1'b1;

  always @(negedge clk) begin
    if (armed) begin
      if (de_m && !de_mp) de_rise.push_back(pos_m);
      if (de_m) de_run++;
      if (!de_m && de_mp) begin de_len.push_back(de_run); de_run = 0; end
      if (!hs_m && hs_mp) hs_start.push_back(pos_m);
      if (!hs_m) hs_run++;
      if (hs_m && !hs_mp) begin hs_len.push_back(hs_run); hs_run = 0; end
      de_mp = de_m;
      hs_mp = hs_m;
    end
  end

  // small-instance one-frame statistics
  bit s_win = 1'b0;
  int s_de = 0, s_vsl = 0, s_fs = 0, s_vb = 0, s_hsl = 0;
  int s_de_rise = -1, s_vs_fall = -1, s_hs_fall = -1;
  logic de_sp = 1'b0, vs_sp = 1'b1, hs_sp = 1'b1;

  always @(negedge clk) begin
    if (armed) begin
      if (s_win && pos_s >= 1 && pos_s < 326) begin
        s_de  += int'(de_s);
        s_vsl += int'(!vs_s);
        s_fs  += int'(fs_s);
        s_vb  += int'(vb_s);
        if (pos_s < 26) s_hsl += int'(!hs_s);
        if (de_s && !de_sp && s_de_rise < 0) s_de_rise = pos_s;
        if (!vs_s && vs_sp && s_vs_fall < 0) s_vs_fall = pos_s;
        if (!hs_s && hs_sp && s_hs_fall < 0) s_hs_fall = pos_s;
      end
      de_sp = de_s;
      vs_sp = vs_s;
      hs_sp = hs_s;
    end
  end

  initial begin
    rst_m = 1'b0;
    rst_s = 1'b0;
    repeat (5) step();
    chk("rst_x", int'(x_m), 0);
    chk("rst_y", int'(y_m), 0);
    chk("rst_de", int'(de_m), 0);
    chk("rst_hsync", int'(hs_m), 1);
    chk("rst_vsync", int'(vs_m), 1);
    chk("rst_vblank", int'(vb_m), 0);
    chk("rst_frame_start", int'(fs_m), 1);
    rst_m = 1'b1;
    rst_s = 1'b1;
    s_win = 1'b1;

    fork
      begin : main_seq
        wait_pos_m(639);
        chk("x_last_active", int'(x_m), 639);
        wait_pos_m(640);
        chk("x_after_active", int'(x_m), 0);
        wait_pos_m(800);
        chk("line1_y", int'(y_m), 1);
        chk("line1_fs", int'(fs_m), 0);
        wait_pos_m(1605);
        chk("de_first_rise", qat(de_rise, 0), 2);
        chk("de_rise_spacing", qat(de_rise, 1) - qat(de_rise, 0), 800);
        chk("de_run_len", qat(de_len, 0), 640);
        chk("hs_low_start", qat(hs_start, 0), 658);
        chk("hs_low_end", qat(hs_start, 0) + qat(hs_len, 0) - 1, 753);
        chk("hs_width_line1", qat(hs_len, 1), 96);

        wait_pos_m(2300);
        chk("mid_y_before", int'(y_m), 2);
        chk("mid_hs_active", int'(hs_m), 0);
        begin
          int nstart;
          nstart = hs_start.size();
          rst_m = 1'b0;
          step();
          chk("mid_rst_x", int'(x_m), 0);
          chk("mid_rst_y", int'(y_m), 0);
          chk("mid_rst_de", int'(de_m), 0);
          chk("mid_rst_hs", int'(hs_m), 1);
          chk("mid_rst_vs", int'(vs_m), 1);
          chk("mid_rst_fs", int'(fs_m), 1);
          rst_m = 1'b1;
          wait_pos_m(700);
          chk("mid_hs_count", hs_start.size(), nstart + 1);
          chk("mid_hs_restart", qat(hs_start, nstart), 658);
        end
        wait_pos_m(700 + 12 * 800);
      end
      begin : small_seq
        wait_pos_s(330);
        chk("s_de_per_frame", s_de, 96);
        chk("s_vs_low_cycles", s_vsl, 50);
        chk("s_vs_fall", s_vs_fall, 201);
        chk("s_fs_per_frame", s_fs, 1);
        chk("s_vblank_cycles", s_vb, 175);
        chk("s_de_first_rise", s_de_rise, 1);
        chk("s_hs_fall", s_hs_fall, 19);
        chk("s_hs_width", s_hsl, 4);
        s_win = 1'b0;

        wait_pos_s(445);
        chk("s_mid_y", int'(y_s), 4);
        chk("s_mid_hs_active", int'(hs_s), 0);
        rst_s = 1'b0;
        step();
        chk("s_rst_x", int'(x_s), 0);
        chk("s_rst_de", int'(de_s), 0);
        chk("s_rst_hs", int'(hs_s), 1);
        chk("s_rst_vs", int'(vs_s), 1);
        chk("s_rst_fs", int'(fs_s), 1);
        rst_s = 1'b1;

        // random reset pulses; the per-cycle model covers every restart
        repeat (20) begin
          repeat ($urandom_range(700, 30)) step();
          rst_s = 1'b0;
          repeat ($urandom_range(3, 1)) step();
          rst_s = 1'b1;
        end
        repeat (400) step();
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
